// File: rtl/controle_varredura_servo_pkg.sv
// Shared definitions for the servo sweep controller: state encodings, position range, step rule.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package controle_varredura_servo_pkg;

    typedef enum logic [2:0] {
        INICIAL   = 3'd0,
        POSICIONA = 3'd1,
        MEDE      = 3'd2,
        AGUARDA   = 3'd3,
        PROXIMA   = 3'd4
    } estado_t;

    localparam logic [2:0] POS_MIN = 3'd0;
    localparam logic [2:0] POS_MAX = 3'd7;

    // Next {sentido, posicao} of the triangle sweep. The direction flips while
    // stepping off an end stop, so each end position is visited once per pass.
    function automatic logic [3:0] avanca(input logic [2:0] pos, input logic sent);
        logic [3:0] r;
        if (sent) begin
            r = (pos == POS_MAX) ? {1'b0, POS_MAX - 3'd1} : {1'b1, pos + 3'd1};
        end else begin
            r = (pos == POS_MIN) ? {1'b1, POS_MIN + 3'd1} : {1'b0, pos - 3'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/controle_varredura_servo_contador.sv
// 32-bit up-counter with synchronous clear, count enable and terminal compare against a runtime limit.
// Latency: count updates one cycle after zera/conta; fim is combinational from the count register.
// Backpressure: none; conta simply holds the count when low.
//   clock, reset : clock and asynchronous active-low reset
//   zera, conta  : synchronous clear (wins over conta), count enable
//   limite       : terminal value; fim is high while the count equals it
module contador_m_sclr (
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        conta,
    input  logic [31:0] limite,
    output logic        fim
);

    logic [31:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta) begin
            valor <= valor + 32'd1;
        end
    end

    assign fim = (valor == limite);

endmodule

// File: rtl/controle_varredura_servo.sv
// Sweeps posicao 0..7..0, settles at each position, pulses medir, waits for fim_medida or a timeout.
// Latency: ligar sampled -> medir after ESPERA_POSICAO+1 cycles; step period ESPERA_POSICAO+3 with immediate fim_medida.
// Backpressure: none; fim_medida is only looked at in AGUARDA, ligar=0 aborts to INICIAL from any state.
//   clock, reset      : clock and asynchronous active-low reset
//   ligar, fim_medida : sweep enable (level), measurement done
//   posicao, sentido  : servo position code and sweep direction (1 = increasing)
//   medir, timeout    : one-cycle measurement request / missing-answer pulse
//   ativo, db_estado  : not idle, current state code
module controle_varredura_servo
    import controle_varredura_servo_pkg::*;
#(
    parameter int unsigned ESPERA_POSICAO = 25_000_000,
    parameter int unsigned TIMEOUT_MEDIDA = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_medida,
    output logic [2:0] posicao,
    output logic       sentido,
    output logic       medir,
    output logic       timeout,
    output logic       ativo,
    output logic [2:0] db_estado
);

    localparam logic [31:0] LIM_ESPERA  = 32'(ESPERA_POSICAO - 1);
    localparam logic [31:0] LIM_TIMEOUT = 32'(TIMEOUT_MEDIDA - 1);

    estado_t     estado, proximo;
    logic        zera, conta, fim_contagem, estourou;
    logic [31:0] limite;

    contador_m_sclr u_timer (
        .clock  (clock),
        .reset  (reset),
        .zera   (zera),
        .conta  (conta),
        .limite (limite),
        .fim    (fim_contagem)
    );

    // The counter is cleared on every state exit so it always enters the next
    // timed state at zero and never runs past its limit.
    always_comb begin
        proximo  = estado;
        zera     = 1'b0;
        conta    = 1'b0;
        limite   = LIM_ESPERA;
        estourou = 1'b0;
        case (estado)
            INICIAL: begin
                zera = 1'b1;
                if (ligar) proximo = POSICIONA;
            end
            POSICIONA: begin
                if (fim_contagem) begin
                    proximo = MEDE;
                    zera    = 1'b1;
                end else begin
                    conta = 1'b1;
                end
            end
            MEDE: begin
                zera    = 1'b1;
                proximo = AGUARDA;
            end
            AGUARDA: begin
                limite = LIM_TIMEOUT;
                if (fim_medida) begin
                    proximo = PROXIMA;
                    zera    = 1'b1;
                end else if (fim_contagem) begin
                    proximo  = PROXIMA;
                    zera     = 1'b1;
                    estourou = 1'b1;
                end else begin
                    conta = 1'b1;
                end
            end
            PROXIMA: begin
                zera    = 1'b1;
                proximo = POSICIONA;
            end
            default: begin
                zera    = 1'b1;
                proximo = INICIAL;
            end
        endcase
        if (!ligar && estado != INICIAL) begin
            proximo  = INICIAL;
            zera     = 1'b1;
            conta    = 1'b0;
            estourou = 1'b0;
        end
    end

    // Outputs come from their own flops, loaded from the next-state decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            medir     <= 1'b0;
            timeout   <= 1'b0;
            ativo     <= 1'b0;
            db_estado <= 3'd0;
        end else begin
            estado    <= proximo;
            medir     <= (proximo == MEDE);
            timeout   <= estourou;
            ativo     <= (proximo != INICIAL);
            db_estado <= proximo;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            posicao <= POS_MIN;
            sentido <= 1'b1;
        end else if (proximo == INICIAL) begin
            posicao <= POS_MIN;
            sentido <= 1'b1;
        end else if (estado == PROXIMA) begin
            {sentido, posicao} <= avanca(posicao, sentido);
        end
    end

endmodule

// File: tb/tb_controle_varredura_servo.sv
module tb_controle_varredura_servo;

    localparam int E = 10;
    localparam int T = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       fim_medida = 1'b0;
    logic [2:0] posicao;
    logic       sentido;
    logic       medir;
    logic       timeout;
    logic       ativo;
    logic [2:0] db_estado;

    int vetores = 0;
    int erros = 0;
    int k = 0;   // steps completed since the sweep (re)started

    controle_varredura_servo #(
        .ESPERA_POSICAO (E),
        .TIMEOUT_MEDIDA (T)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ligar      (ligar),
        .fim_medida (fim_medida),
        .posicao    (posicao),
        .sentido    (sentido),
        .medir      (medir),
        .timeout    (timeout),
        .ativo      (ativo),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    task automatic confere(input string tag, input int obs, input int esp);
        vetores++;
        if (obs != esp) begin
            erros++;
            $display("FAIL %s: got %0d expected %0d (step %0d, t=%0t)", tag, obs, esp, k, $time);
        end
    endtask

    task automatic confere_inicial(input string tag);
        confere({tag, "_estado"}, db_estado, 0);
        confere({tag, "_posicao"}, posicao, 0);
        confere({tag, "_sentido"}, sentido, 1);
        confere({tag, "_ativo"}, ativo, 0);
        confere({tag, "_medir"}, medir, 0);
        confere({tag, "_timeout"}, timeout, 0);
    endtask

    // One sweep step, entered at the negedge just before the edge that starts
    // the settle phase. Expected position is a triangle wave of period 14.
    // d: AGUARDA cycle index in which fim_medida is presented (-1 = never).
    task automatic passo(input int d, input bit espurio, input int aborta_j, input bit reset_mede);
        int  p;
        int  pos_esp;
        bit  sent_esp;
        bit  respondeu;
        p         = k % 14;
        pos_esp   = (p <= 7) ? p : 14 - p;
        sent_esp  = (k == 0) ? 1'b1 : (p >= 1 && p <= 7);
        respondeu = 1'b0;
        for (int i = 0; i < E; i++) begin
            @(posedge clock); @(negedge clock);
            fim_medida = espurio && (i == E / 2);
            confere("medir_assentando", medir, 0);
            if (i == 0) begin
                confere("posicao", posicao, pos_esp);
                confere("sentido", sentido, sent_esp);
                confere("estado_posiciona", db_estado, 1);
                confere("ativo", ativo, 1);
            end
        end
        @(posedge clock); @(negedge clock);
        confere("medir_pulso", medir, 1);
        confere("estado_mede", db_estado, 2);
        confere("timeout_mede", timeout, 0);
        fim_medida = espurio;
        if (reset_mede) begin
            #1 reset = 1'b0;
            #1;
            confere_inicial("reset_assinc");
            fim_medida = 1'b0;
            k = 0;
            return;
        end
        for (int j = 0; j < T; j++) begin
            @(posedge clock); @(negedge clock);
            confere("medir_aguarda", medir, 0);
            confere("timeout_aguarda", timeout, 0);
            confere("estado_aguarda", db_estado, 3);
            if (j == aborta_j) begin
                ligar = 1'b0;
                fim_medida = 1'b0;
                @(posedge clock); @(negedge clock);
                confere_inicial("desliga");
                k = 0;
                return;
            end
            fim_medida = (j == d);
            if (j == d) begin
                respondeu = 1'b1;
                break;
            end
        end
        @(posedge clock); @(negedge clock);
        fim_medida = 1'b0;
        confere("estado_proxima", db_estado, 4);
        confere("timeout_proxima", timeout, respondeu ? 0 : 1);
        confere("posicao_retida", posicao, pos_esp);
        confere("medir_proxima", medir, 0);
        k++;
    endtask

    function automatic int atraso_aleatorio();
        int d;
        d = int'($urandom_range(0, T + 4));
        return (d >= T) ? -1 : d;
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        confere_inicial("reset");
        reset = 1'b1;
        @(negedge clock);
        confere_inicial("ocioso");
        ligar = 1'b1;

        // full back-and-forth pass with fim_medida two cycles after medir
        for (int s = 0; s < 16; s++) passo(2, 1'b0, -1, 1'b0);
        passo(-1, 1'b0, -1, 1'b0);        // no answer: timeout path
        passo(T - 1, 1'b0, -1, 1'b0);     // answer coincides with the timeout cycle
        passo(-1, 1'b1, -1, 1'b0);        // stray fim_medida outside AGUARDA
        passo(3, 1'b1, -1, 1'b0);
        for (int s = 0; s < 20; s++) passo(atraso_aleatorio(), 1'($urandom_range(0, 1)), -1, 1'b0);

        // drop ligar while waiting at position 5 on the way down
        while (k % 14 != 9) passo(atraso_aleatorio(), 1'b0, -1, 1'b0);
        passo(-1, 1'b0, int'($urandom_range(0, T - 1)), 1'b0);
        ligar = 1'b1;
        passo(1, 1'b0, -1, 1'b0);
        passo(0, 1'b0, -1, 1'b0);

        // asynchronous reset while medir is high
        passo(atraso_aleatorio(), 1'b0, -1, 1'b0);
        passo(0, 1'b0, -1, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        for (int s = 0; s < 4; s++) passo(atraso_aleatorio(), 1'b0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
